cmu_result_collector: RTL
=========================

// Module: cmu_result_collector
// PURPOSE
// - Receiving end of the CMU channel interface (data + single-cycle valid, no backpressure).
// - Takes results from N_CH parallel CMU channels and writes each into a symmetric DIMxDIM
//   predicted-covariance store. Only the upper triangle is kept; reads are mirrored.
// - Raises frame_done once every unique element of a frame has been written.
//   The next Kalman stage then reads the matrix through the rd_* port.
// PARAMETERS
// - DBL_WIDTH  64  IEEE-754 double word width
// - N_CH        4  number of CMU result channels (1..8)
// - DIM        12  matrix dimension; N_ELEM = DIM*(DIM+1)/2 = 78 stored words
// - IDX_W       4  row/col index width; must satisfy 2**IDX_W >= DIM
// PORTS
// - clk          in   1              single clock, rising edge
// - rst          in   1              asynchronous, active-high reset
// - frame_start  in   1              clears bitmap/count/holds/errors; opens a new frame
// - ch_valid     in   N_CH           per-channel result pulse (CMU valid_out)
// - ch_data      in   N_CH*DBL_WIDTH per-channel result (CMU a), channel k at [k*64+:64]
// - ch_row       in   N_CH*IDX_W     target row for channel k
// - ch_col       in   N_CH*IDX_W     target column for channel k
// - rd_en        in   1              read request
// - rd_row       in   IDX_W          read row
// - rd_col       in   IDX_W          read column
// - rd_data      out  DBL_WIDTH      read data, registered
// - rd_valid     out  1              rd_data valid, exactly 1 cycle after rd_en
// - frame_done   out  1              all N_ELEM elements written; sticky until frame_start
// - busy         out  1              frame open and not yet done
// - elem_count   out  7              unique elements written in the current frame
// - ovf_err      out  1              sticky: result lost because the hold register was full
// - dup_err      out  1              sticky: element written twice in one frame
// - idx_err      out  1              sticky: row or col >= DIM; that result is dropped
// BEHAVIOUR
// - Reset: all outputs 0, holds empty, bitmap clear, arbiter pointer 0. Storage array is not reset.
// - Index fold: if row>col, swap them.
//   - addr = r*DIM - r*(r-1)/2 + (c-r); unsigned arithmetic, 7-bit result.
// - Per channel, one hold register {data, addr, full}.
//   - On an edge where ch_valid[k]=1 and the range check passes, the hold loads and full is set.
// - Arbiter: round-robin over full holds, starting from ptr.
//   - One grant per cycle; the winning word is written to storage on the next edge.
//   - After a grant, ptr moves to winner+1 (mod N_CH).
// - Latency: valid at edge t -> hold at t -> storage write at t+1 when uncontended.
//   - Worst case is t+N_CH.
// - Simultaneous events on one channel:
//   - Hold granted and new valid in the same cycle: the new word is accepted, no error.
//   - Hold full, not granted, new valid: new word dropped, ovf_err set, old word kept.
// - Bitmap: on write, if bit[addr] is already set, set dup_err and overwrite the data.
//   - elem_count is not incremented in that case.
//   - Otherwise set the bit and do elem_count+1.
// - frame_done rises on the edge where elem_count reaches N_ELEM.
//   - busy = frame_open & ~frame_done.
// - frame_start has priority over every other update in its cycle.
//   - It clears holds, bitmap, count, frame_done and the errors, and sets frame_open.
//   - A ch_valid in the same cycle is captured into the new frame.
//   - frame_start mid-frame aborts the frame; pending holds are discarded.
// - Valids arriving while frame_open=0 (frame not started) are still accepted.
// - Valids arriving after frame_done are treated as duplicates: dup_err is set.
// - Read path:
//   - Same fold and addr as the write side.
//   - rd_data is registered; reads ignore the bitmap (data from a previous frame may be returned).
//   - rd_row or rd_col >= DIM: rd_data=0, rd_valid still asserts.
//   - Read and write to the same addr in the same cycle: the read returns the old value.
// STRUCTURE
// - kalman_pkg: DBL_WIDTH, DIM and N_ELEM constants, plus function tri_addr(row, col).
//   - tri_addr folds the indices and returns the addr; it is shared with the operand feeder.
// - Sub-module rr_arbiter #(N): inputs req[N]; outputs grant one-hot and grant_idx.
//   - Its pointer register lives inside the sub-module.
// - Storage: a 78x64 array, one write port and one read port. It is inferred as distributed RAM.
// TESTING
// - Reset, then frame_start, then 78 unique writes spread over 4 channels.
//   - Required: frame_done=1 one edge after the 78th commit, elem_count=78, no errors.
// - Write (2,5)=0x4000_0000_0000_0000 (2.0), then read (5,2) and (2,5).
//   - Required: both return 2.0 with rd_valid one cycle later.
// - All 4 channels pulse in the same cycle.
//   - Required: commits in ptr order over 4 consecutive cycles, no ovf_err.
// - ch_valid[0] held high 2 cycles while ch1..3 hold ptr priority.
//   - Required: ovf_err=1 and the first word is kept.
// - Write (3,3) twice: dup_err=1, count unchanged, data equals the second word.
//   - Index (12,0) sets idx_err and is dropped.
// - frame_start at elem_count=40 with holds pending, and again asserted with ch_valid.
//   - Required: count resets to 0 (1 if a valid came with frame_start), errors clear, frame_done=0.

Source files
------------

// File: rtl/cmu_result_collector_pkg.sv
// Shared constants and helpers for the Kalman predicted-covariance path.
// - DBL_WIDTH : IEEE-754 double word width
// - DIM       : covariance matrix dimension
// - IDX_W     : row/col index width
// - N_ELEM    : unique upper-triangle elements of a DIMxDIM symmetric matrix
// - tri_addr  : folds (row, col) into the upper triangle and returns the packed address
package cmu_result_collector_pkg;

  localparam int unsigned DBL_WIDTH = 64;
  localparam int unsigned DIM       = 12;
  localparam int unsigned IDX_W     = 4;
  localparam int unsigned N_ELEM    = DIM * (DIM + 1) / 2;
  localparam int unsigned ADDR_W    = 7;

  typedef logic [ADDR_W-1:0] addr_t;

  typedef enum logic [1:0] {
    FR_IDLE,
    FR_OPEN,
    FR_DONE
  } frame_state_t;

  // Row-major packing of the upper triangle: row r starts at r*DIM - r*(r-1)/2.
  function automatic addr_t tri_addr(input logic [IDX_W-1:0] row,
                                     input logic [IDX_W-1:0] col);
    int unsigned r;
    int unsigned c;
    r = (row > col) ? 32'(col) : 32'(row);
    c = (row > col) ? 32'(row) : 32'(col);
    return addr_t'(r * DIM - (r * (r - 1)) / 2 + (c - r));
  endfunction

endpackage

// File: rtl/cmu_result_collector_if.sv
// CMU result channel bundle: N_CH parallel channels, each a single-cycle valid
// pulse with a data word and its target (row, col). No backpressure.
// - master : CMU side (drives everything)
// - slave  : collector side
interface cmu_result_collector_if #(
  parameter int unsigned N_CH      = 4,
  parameter int unsigned DBL_WIDTH = 64,
  parameter int unsigned IDX_W     = 4
);

  logic [N_CH-1:0]           ch_valid;
  logic [N_CH*DBL_WIDTH-1:0] ch_data;
  logic [N_CH*IDX_W-1:0]     ch_row;
  logic [N_CH*IDX_W-1:0]     ch_col;

  modport master (output ch_valid, ch_data, ch_row, ch_col);
  modport slave  (input  ch_valid, ch_data, ch_row, ch_col);

endinterface

// File: rtl/cmu_result_collector_rr_arbiter.sv
// Round-robin arbiter: one grant per cycle among asserted requests, searching
// from an internal pointer that moves to winner+1 after each grant.
// - clk, rst  : clock, asynchronous active-high reset (pointer -> 0)
// - req       : request vector
// - grant     : one-hot grant (combinational)
// - grant_idx : index of the granted requester
module rr_arbiter #(
  parameter int unsigned N = 4
) (
  input  logic                               clk,
  input  logic                               rst,
  input  logic [N-1:0]                       req,
  output logic [N-1:0]                       grant,
  output logic [$clog2((N > 1) ? N : 2)-1:0] grant_idx
);

  localparam int unsigned IW = $clog2((N > 1) ? N : 2);

  logic [IW-1:0] ptr;
  logic          found;

  always_comb begin
    grant     = '0;
    grant_idx = '0;
    found     = 1'b0;
    for (int unsigned i = 0; i < N; i++) begin
      if (!found && req[(32'(ptr) + i) % N]) begin
        found                         = 1'b1;
        grant[(32'(ptr) + i) % N]     = 1'b1;
        grant_idx                     = IW'((32'(ptr) + i) % N);
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ptr <= '0;
    end else if (found) begin
      ptr <= (32'(grant_idx) == N - 1) ? '0 : grant_idx + 1'b1;
    end
  end

endmodule

// File: rtl/cmu_result_collector.sv
// Collects CMU channel results into the symmetric predicted-covariance store
// (upper triangle only, mirrored reads) and flags frame completion.
// - clk, rst            : clock, asynchronous active-high reset
// - frame_start         : clears bitmap/count/holds/errors, opens a new frame
// - ch                  : CMU result channels (slave side)
// - rd_en/rd_row/rd_col : read request; rd_data/rd_valid one cycle later
// - frame_done, busy    : all unique elements written / frame open and not done
// - elem_count          : unique elements written in the current frame
// - ovf_err/dup_err/idx_err : sticky error flags, cleared by frame_start
module cmu_result_collector #(
  parameter int unsigned DBL_WIDTH = 64,
  parameter int unsigned N_CH      = 4,
  parameter int unsigned DIM       = 12,
  parameter int unsigned IDX_W     = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 frame_start,
  cmu_result_collector_if.slave ch,
  input  logic                 rd_en,
  input  logic [IDX_W-1:0]     rd_row,
  input  logic [IDX_W-1:0]     rd_col,
  output logic [DBL_WIDTH-1:0] rd_data,
  output logic                 rd_valid,
  output logic                 frame_done,
  output logic                 busy,
  output logic [6:0]           elem_count,
  output logic                 ovf_err,
  output logic                 dup_err,
  output logic                 idx_err
);

  import cmu_result_collector_pkg::*;

  localparam int unsigned GW = $clog2((N_CH > 1) ? N_CH : 2);

  logic [N_CH-1:0]      hold_full;
  logic [DBL_WIDTH-1:0] hold_data [N_CH];
  addr_t                hold_addr [N_CH];

  logic [N_CH-1:0]      in_rng;
  addr_t                in_addr [N_CH];
  logic [N_CH-1:0]      req;
  logic [N_CH-1:0]      grant;
  logic [GW-1:0]        grant_idx;

  logic                 wr_en;
  addr_t                wr_addr;
  logic [DBL_WIDTH-1:0] wr_data;

  logic [N_ELEM-1:0]    written;
  frame_state_t         state;
  logic [DBL_WIDTH-1:0] mem [N_ELEM];

  logic                 rd_in_rng;
  addr_t                rd_addr;

  always_comb begin
    in_rng = '0;
    req    = '0;
    for (int unsigned k = 0; k < N_CH; k++) begin
      in_rng[k]  = (32'(ch.ch_row[k*IDX_W +: IDX_W]) < DIM) &&
                   (32'(ch.ch_col[k*IDX_W +: IDX_W]) < DIM);
      in_addr[k] = tri_addr(ch.ch_row[k*IDX_W +: IDX_W], ch.ch_col[k*IDX_W +: IDX_W]);
      // frame_start discards pending holds, so nothing may commit that cycle.
      req[k]     = hold_full[k] & ~frame_start;
    end
  end

  rr_arbiter #(.N(N_CH)) u_arb (
    .clk       (clk),
    .rst       (rst),
    .req       (req),
    .grant     (grant),
    .grant_idx (grant_idx)
  );

  assign wr_en   = |grant;
  assign wr_addr = hold_addr[grant_idx];
  assign wr_data = hold_data[grant_idx];

  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_addr] <= wr_data;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hold_full  <= '0;
      for (int unsigned k = 0; k < N_CH; k++) begin
        hold_data[k] <= '0;
        hold_addr[k] <= '0;
      end
      written    <= '0;
      elem_count <= '0;
      state      <= FR_IDLE;
      frame_done <= 1'b0;
      busy       <= 1'b0;
      ovf_err    <= 1'b0;
      dup_err    <= 1'b0;
      idx_err    <= 1'b0;
    end else if (frame_start) begin
      written    <= '0;
      elem_count <= '0;
      state      <= FR_OPEN;
      frame_done <= 1'b0;
      busy       <= 1'b1;
      ovf_err    <= 1'b0;
      dup_err    <= 1'b0;
      idx_err    <= 1'b0;
      for (int unsigned k = 0; k < N_CH; k++) begin
        hold_full[k] <= ch.ch_valid[k] & in_rng[k];
        hold_data[k] <= ch.ch_data[k*DBL_WIDTH +: DBL_WIDTH];
        hold_addr[k] <= in_addr[k];
      end
    end else begin
      if (wr_en) begin
        if (written[wr_addr]) begin
          dup_err <= 1'b1;
        end else begin
          written[wr_addr] <= 1'b1;
          elem_count       <= elem_count + 7'd1;
          if (32'(elem_count) == N_ELEM - 1) begin
            state      <= FR_DONE;
            frame_done <= 1'b1;
            busy       <= 1'b0;
          end
        end
      end
      for (int unsigned k = 0; k < N_CH; k++) begin
        if (grant[k]) begin
          hold_full[k] <= 1'b0;
        end
        // A hold drained this cycle may reload in the same cycle.
        if (ch.ch_valid[k]) begin
          if (!in_rng[k]) begin
            idx_err <= 1'b1;
          end else if (hold_full[k] && !grant[k]) begin
            ovf_err <= 1'b1;
          end else begin
            hold_full[k] <= 1'b1;
            hold_data[k] <= ch.ch_data[k*DBL_WIDTH +: DBL_WIDTH];
            hold_addr[k] <= in_addr[k];
          end
        end
      end
    end
  end

  assign rd_in_rng = (32'(rd_row) < DIM) && (32'(rd_col) < DIM);
  assign rd_addr   = tri_addr(rd_row, rd_col);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_data  <= '0;
      rd_valid <= 1'b0;
    end else begin
      rd_valid <= rd_en;
      if (rd_en) begin
        rd_data <= rd_in_rng ? mem[rd_addr] : '0;
      end
    end
  end

endmodule
